// File: rtl/i2c_pkg.sv
// Shared I2C definitions: responder FSM states, ACK/NACK levels and R/W bit values.
// Also used by the controller side (i2c_core).
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX_DATA,
        ST_RX_ACK,
        ST_TX_DATA,
        ST_TX_ACK,
        ST_WAIT_STOP
    } i2c_slv_state_t;

    localparam logic ACK         = 1'b0;
    localparam logic NACK        = 1'b1;
    localparam logic RW_WRITE    = 1'b0;
    localparam logic RW_READ     = 1'b1;
    localparam logic SDA_RELEASE = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronises raw SCL/SDA into the core clock domain and flags SCL edges and
// START/STOP conditions from the synchronised level plus one history register.
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sdaLevel_o,
    output logic sclRise_o,
    output logic sclFall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] sclSync_q;
    logic [SYNC_STAGES-1:0] sdaSync_q;
    logic                   sclPrev_q;
    logic                   sdaPrev_q;
    logic                   sclLevel;
    logic                   sdaLevel;

    // Reset to the idle bus level so leaving reset on a quiet bus raises no events.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclSync_q <= '1;
            sdaSync_q <= '1;
            sclPrev_q <= 1'b1;
            sdaPrev_q <= 1'b1;
        end else begin
            sclSync_q <= {sclSync_q[SYNC_STAGES-2:0], scl_i};
            sdaSync_q <= {sdaSync_q[SYNC_STAGES-2:0], sda_i};
            sclPrev_q <= sclLevel;
            sdaPrev_q <= sdaLevel;
        end
    end

    assign sclLevel   = sclSync_q[SYNC_STAGES-1];
    assign sdaLevel   = sdaSync_q[SYNC_STAGES-1];
    assign sdaLevel_o = sdaLevel;
    assign sclRise_o  = sclLevel & ~sclPrev_q;
    assign sclFall_o  = ~sclLevel & sclPrev_q;
    assign start_o    = sclLevel & sclPrev_q & sdaPrev_q & ~sdaLevel;
    assign stop_o     = sclLevel & sclPrev_q & ~sdaPrev_q & sdaLevel;

endmodule

// File: rtl/i2c_slave_core.sv
// I2C responder: address match, byte receive/transmit over a pulse-based local
// interface, open-drain SDA drive changed only on detected SCL falls.
module i2c_slave_core
    import i2c_pkg::*;
#(
    parameter int DATA_SIZE   = 8,
    parameter int ADDR_SIZE   = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i2c_core_clk_i,
    input  logic                 i2c_core_rst_i,
    input  logic                 enable_i,
    input  logic [ADDR_SIZE-1:0] own_addr_i,
    input  logic                 i2c_scl_i,
    input  logic                 i2c_sda_i,
    output logic                 i2c_sda_o,
    input  logic [DATA_SIZE-1:0] tx_data_i,
    output logic                 tx_req_o,
    output logic [DATA_SIZE-1:0] rx_data_o,
    output logic                 rx_valid_o,
    output logic                 rw_o,
    output logic                 busy_o,
    output logic                 stop_o,
    output logic                 interrupt_o
);

    localparam int CNT_W = $clog2(DATA_SIZE + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_SIZE);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    i2c_slv_state_t       state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_SIZE-1:0] shift_q, shift_d;
    logic [DATA_SIZE-1:0] rxData_q, rxData_d;
    logic                 ackPhase_q, ackPhase_d;
    logic                 sdaOut_q, sdaOut_d;
    logic                 rxValid_q, rxValid_d;
    logic                 txReq_q, txReq_d;
    logic                 rw_q, rw_d;
    logic                 busy_q, busy_d;
    logic                 stop_q, stop_d;

    logic                 sdaLevel;
    logic                 sclRise;
    logic                 sclFall;
    logic                 startEv;
    logic                 stopEv;
    logic                 addrMatch;
    logic [DATA_SIZE-1:0] shiftIn;

    i2c_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i     (i2c_core_clk_i),
        .rst_i     (i2c_core_rst_i),
        .scl_i     (i2c_scl_i),
        .sda_i     (i2c_sda_i),
        .sdaLevel_o(sdaLevel),
        .sclRise_o (sclRise),
        .sclFall_o (sclFall),
        .start_o   (startEv),
        .stop_o    (stopEv)
    );

    // The seven address bits already shifted in sit below the incoming R/W bit.
    assign addrMatch = enable_i && (shift_q[ADDR_SIZE-1:0] == own_addr_i)
                       && (own_addr_i != '0);
    assign shiftIn   = {shift_q[DATA_SIZE-2:0], sdaLevel};

    always_ff @(posedge i2c_core_clk_i) begin
        if (i2c_core_rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            rxData_q   <= '0;
            ackPhase_q <= 1'b0;
            sdaOut_q   <= SDA_RELEASE;
            rxValid_q  <= 1'b0;
            txReq_q    <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rxData_q   <= rxData_d;
            ackPhase_q <= ackPhase_d;
            sdaOut_q   <= sdaOut_d;
            rxValid_q  <= rxValid_d;
            txReq_q    <= txReq_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
            stop_q     <= stop_d;
        end
    end

    // ackPhase_q marks the second half of an ACK slot: SDA held (or sampled) until the slot ends.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rxData_d   = rxData_q;
        ackPhase_d = ackPhase_q;
        sdaOut_d   = sdaOut_q;
        rxValid_d  = 1'b0;
        txReq_d    = 1'b0;
        rw_d       = rw_q;
        busy_d     = busy_q;
        stop_d     = 1'b0;

        if (stopEv) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            ackPhase_d = 1'b0;
            sdaOut_d   = SDA_RELEASE;
            busy_d     = 1'b0;
            stop_d     = 1'b1;
        end else if (startEv) begin
            state_d    = ST_ADDR;
            cnt_d      = '0;
            shift_d    = '0;
            ackPhase_d = 1'b0;
            sdaOut_d   = SDA_RELEASE;
            busy_d     = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                end
                ST_ADDR: begin
                    if (sclRise) begin
                        shift_d = shiftIn;
                        cnt_d   = cnt_q + CNT_ONE;
                        if (cnt_q == ADDR_LAST) begin
                            cnt_d = '0;
                            if (addrMatch) begin
                                state_d = ST_ADDR_ACK;
                                rw_d    = sdaLevel;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = ST_WAIT_STOP;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (sclFall && !ackPhase_q) begin
                        sdaOut_d   = ACK;
                        ackPhase_d = 1'b1;
                    end else if (sclRise && ackPhase_q && rw_q == RW_READ) begin
                        txReq_d = 1'b1;
                    end else if (sclFall && ackPhase_q) begin
                        ackPhase_d = 1'b0;
                        if (rw_q == RW_READ) begin
                            shift_d  = tx_data_i;
                            sdaOut_d = tx_data_i[DATA_SIZE-1];
                            state_d  = ST_TX_DATA;
                        end else begin
                            sdaOut_d = SDA_RELEASE;
                            state_d  = ST_RX_DATA;
                        end
                    end
                end
                ST_RX_DATA: begin
                    if (sclRise) begin
                        shift_d = shiftIn;
                        cnt_d   = cnt_q + CNT_ONE;
                        if (cnt_q == DATA_LAST) begin
                            cnt_d     = '0;
                            rxData_d  = shiftIn;
                            rxValid_d = 1'b1;
                            state_d   = ST_RX_ACK;
                        end
                    end
                end
                ST_RX_ACK: begin
                    if (sclFall) begin
                        if (!ackPhase_q) begin
                            sdaOut_d   = ACK;
                            ackPhase_d = 1'b1;
                        end else begin
                            sdaOut_d   = SDA_RELEASE;
                            ackPhase_d = 1'b0;
                            state_d    = ST_RX_DATA;
                        end
                    end
                end
                ST_TX_DATA: begin
                    if (sclFall) begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_q == DATA_LAST) begin
                            cnt_d    = '0;
                            sdaOut_d = SDA_RELEASE;
                            state_d  = ST_TX_ACK;
                        end else begin
                            shift_d  = {shift_q[DATA_SIZE-2:0], shift_q[DATA_SIZE-1]};
                            sdaOut_d = shift_q[DATA_SIZE-2];
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (sclRise && !ackPhase_q) begin
                        if (sdaLevel == ACK) begin
                            txReq_d    = 1'b1;
                            ackPhase_d = 1'b1;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = ST_WAIT_STOP;
                        end
                    end else if (sclFall && ackPhase_q) begin
                        ackPhase_d = 1'b0;
                        shift_d    = tx_data_i;
                        sdaOut_d   = tx_data_i[DATA_SIZE-1];
                        state_d    = ST_TX_DATA;
                    end
                end
                ST_WAIT_STOP: begin
                    sdaOut_d = SDA_RELEASE;
                end
                default: begin
                    state_d  = ST_IDLE;
                    sdaOut_d = SDA_RELEASE;
                end
            endcase
        end
    end

    assign i2c_sda_o   = sdaOut_q;
    assign tx_req_o    = txReq_q;
    assign rx_data_o   = rxData_q;
    assign rx_valid_o  = rxValid_q;
    assign rw_o        = rw_q;
    assign busy_o      = busy_q;
    assign stop_o      = stop_q;
    assign interrupt_o = rxValid_q | txReq_q | stop_q;

endmodule

// File: tb/tb_i2c_slave_core.sv
// Bit-banged I2C controller driving i2c_slave_core over a wired-AND SDA bus,
// with directed frames followed by randomised frames checked against a transaction model.
module tb_i2c_slave_core;
    import i2c_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [6:0] ownAddr;
    logic       mScl;
    logic       mSda;
    logic [7:0] txData;
    logic       dutSda;
    logic       txReq;
    logic       rxValid;
    logic       rw;
    logic       busy;
    logic       stopPulse;
    logic       intr;
    logic [7:0] rxData;
    logic       sdaBus;

    int checks = 0;
    int passes = 0;
    int fails = 0;
    int rxCount = 0;
    int txReqCount = 0;
    int stopCount = 0;
    int intErr = 0;
    logic sdaLowSeen = 1'b0;
    logic [7:0] rxLog[$];
    logic [7:0] txQueue[$];
    logic [7:0] bytesQ[$];

    logic       ack;
    logic [7:0] got;
    logic [6:0] rAddr;
    logic       rRw;
    logic       expAck;
    int         rLen;

    always #5 clk = ~clk;
    assign sdaBus = mSda & dutSda;

    i2c_slave_core #(
        .DATA_SIZE  (8),
        .ADDR_SIZE  (7),
        .SYNC_STAGES(2)
    ) dut (
        .i2c_core_clk_i(clk),
        .i2c_core_rst_i(rst),
        .enable_i      (enable),
        .own_addr_i    (ownAddr),
        .i2c_scl_i     (mScl),
        .i2c_sda_i     (sdaBus),
        .i2c_sda_o     (dutSda),
        .tx_data_i     (txData),
        .tx_req_o      (txReq),
        .rx_data_o     (rxData),
        .rx_valid_o    (rxValid),
        .rw_o          (rw),
        .busy_o        (busy),
        .stop_o        (stopPulse),
        .interrupt_o   (intr)
    );

    // Local-logic side: log received bytes, serve read bytes the cycle after each request.
    always @(negedge clk) begin
        if (rxValid === 1'b1) begin
            rxCount++;
            rxLog.push_back(rxData);
        end
        if (txReq === 1'b1) begin
            txReqCount++;
            txData = (txQueue.size() > 0) ? txQueue.pop_front() : 8'hFF;
        end
        if (stopPulse === 1'b1) stopCount++;
        if (intr !== (rxValid | txReq | stopPulse)) intErr++;
        if (dutSda === 1'b0) sdaLowSeen = 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic sclLvl, input logic sdaLvl, input int clks);
        mScl = sclLvl;
        mSda = sdaLvl;
        repeat (clks) @(negedge clk);
    endtask

    task automatic bitSlot(input logic b, output logic sampled);
        applyStimulus(1'b0, mSda, 2);
        applyStimulus(1'b0, b, 6);
        applyStimulus(1'b1, b, 4);
        sampled = sdaBus;
        applyStimulus(1'b1, b, 4);
        applyStimulus(1'b0, b, 0);
    endtask

    task automatic busStart();
        applyStimulus(1'b1, 1'b1, 4);
        applyStimulus(1'b1, 1'b0, 8);
        applyStimulus(1'b0, 1'b0, 0);
    endtask

    task automatic busRepStart();
        applyStimulus(1'b0, mSda, 2);
        applyStimulus(1'b0, 1'b1, 6);
        applyStimulus(1'b1, 1'b1, 8);
        applyStimulus(1'b1, 1'b0, 8);
        applyStimulus(1'b0, 1'b0, 0);
    endtask

    task automatic busStop();
        applyStimulus(1'b0, mSda, 2);
        applyStimulus(1'b0, 1'b0, 6);
        applyStimulus(1'b1, 1'b0, 8);
        applyStimulus(1'b1, 1'b1, 12);
    endtask

    task automatic writeByte(input logic [7:0] b, output logic ackOut);
        logic s;
        for (int i = 7; i >= 0; i--) bitSlot(b[i], s);
        bitSlot(1'b1, ackOut);
    endtask

    task automatic readByte(input logic ackBit, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bitSlot(1'b1, s);
            b[i] = s;
        end
        bitSlot(ackBit, s);
    endtask

    task automatic clearLog();
        rxCount = 0;
        txReqCount = 0;
        stopCount = 0;
        sdaLowSeen = 1'b0;
        rxLog.delete();
        txQueue.delete();
    endtask

    function automatic logic [7:0] logAt(input int i);
        return (rxLog.size() > i) ? rxLog[i] : 8'hxx;
    endfunction

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        ownAddr = 7'h50;
        mScl = 1'b1;
        mSda = 1'b1;
        txData = 8'h00;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_sda", dutSda, 1'b1);
        checkOutput("rst_txreq", txReq, 1'b0);
        checkOutput("rst_rxvalid", rxValid, 1'b0);
        checkOutput("rst_rxdata", rxData, 8'h00);
        checkOutput("rst_rw", rw, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_stop", stopPulse, 1'b0);
        checkOutput("rst_int", intr, 1'b0);

        // Write two bytes; enable drops after the address and must not affect the transfer.
        clearLog();
        busStart();
        writeByte({7'h50, RW_WRITE}, ack);
        checkOutput("t1_addr_ack", ack, ACK);
        enable = 1'b0;
        writeByte(8'hA5, ack);
        checkOutput("t1_b1_ack", ack, ACK);
        writeByte(8'h3C, ack);
        checkOutput("t1_b2_ack", ack, ACK);
        checkOutput("t1_busy", busy, 1'b1);
        busStop();
        enable = 1'b1;
        checkOutput("t1_rxcount", rxCount, 2);
        checkOutput("t1_rx0", logAt(0), 8'hA5);
        checkOutput("t1_rx1", logAt(1), 8'h3C);
        checkOutput("t1_stop", stopCount, 1);
        checkOutput("t1_rw", rw, RW_WRITE);
        checkOutput("t1_busy_end", busy, 1'b0);

        // Read two bytes, master NACKs the second.
        clearLog();
        txQueue.push_back(8'h96);
        txQueue.push_back(8'h0F);
        busStart();
        writeByte({7'h50, RW_READ}, ack);
        checkOutput("t2_addr_ack", ack, ACK);
        readByte(ACK, got);
        checkOutput("t2_rd0", got, 8'h96);
        readByte(NACK, got);
        checkOutput("t2_rd1", got, 8'h0F);
        checkOutput("t2_busy_nack", busy, 1'b0);
        checkOutput("t2_state_nack", 32'(dut.state_q), 32'(ST_WAIT_STOP));
        busStop();
        checkOutput("t2_txreq", txReqCount, 2);
        checkOutput("t2_rw", rw, RW_READ);
        checkOutput("t2_stop", stopCount, 1);

        // Non-matching address: bus untouched, only stop_o.
        clearLog();
        busStart();
        writeByte({7'h51, RW_WRITE}, ack);
        checkOutput("t3_addr_nack", ack, NACK);
        writeByte(8'hA5, ack);
        checkOutput("t3_data_nack", ack, NACK);
        busStop();
        checkOutput("t3_sda_low", sdaLowSeen, 1'b0);
        checkOutput("t3_rx", rxCount, 0);
        checkOutput("t3_tx", txReqCount, 0);
        checkOutput("t3_stop", stopCount, 1);

        // Write, repeated START, read.
        clearLog();
        busStart();
        writeByte({7'h50, RW_WRITE}, ack);
        checkOutput("t4_w_ack", ack, ACK);
        checkOutput("t4_rw0", rw, RW_WRITE);
        writeByte(8'h11, ack);
        checkOutput("t4_b_ack", ack, ACK);
        txQueue.push_back(8'h5A);
        busRepStart();
        writeByte({7'h50, RW_READ}, ack);
        checkOutput("t4_r_ack", ack, ACK);
        checkOutput("t4_rw1", rw, RW_READ);
        checkOutput("t4_busy", busy, 1'b1);
        readByte(NACK, got);
        checkOutput("t4_rd", got, 8'h5A);
        busStop();
        checkOutput("t4_rx0", logAt(0), 8'h11);
        checkOutput("t4_txreq", txReqCount, 1);
        checkOutput("t4_stop", stopCount, 1);

        // Reset while the address ACK is being driven.
        clearLog();
        busStart();
        for (int i = 7; i >= 0; i--) bitSlot(got[0] ? 1'b0 : 1'b0, ack);
        busStop();
        clearLog();
        busStart();
        begin
            logic [7:0] a;
            a = {7'h50, RW_WRITE};
            for (int i = 7; i >= 0; i--) bitSlot(a[i], ack);
        end
        applyStimulus(1'b0, 1'b1, 8);
        checkOutput("t5_ack_driven", dutSda, ACK);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t5_sda_rst", dutSda, 1'b1);
        checkOutput("t5_state_rst", 32'(dut.state_q), 32'(ST_IDLE));
        checkOutput("t5_busy_rst", busy, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 4);
        applyStimulus(1'b1, 1'b1, 8);
        clearLog();
        busStart();
        writeByte({7'h50, RW_WRITE}, ack);
        checkOutput("t5_addr_ack", ack, ACK);
        writeByte(8'hC3, ack);
        checkOutput("t5_b_ack", ack, ACK);
        busStop();
        checkOutput("t5_rx0", logAt(0), 8'hC3);

        // Disabled responder NACKs its own address.
        clearLog();
        enable = 1'b0;
        busStart();
        writeByte({7'h50, RW_WRITE}, ack);
        checkOutput("t6_nack", ack, NACK);
        checkOutput("t6_state", 32'(dut.state_q), 32'(ST_WAIT_STOP));
        checkOutput("t6_busy", busy, 1'b0);
        busStop();
        enable = 1'b1;
        checkOutput("t6_idle", 32'(dut.state_q), 32'(ST_IDLE));
        checkOutput("t6_sda_low", sdaLowSeen, 1'b0);

        // Own address zero never matches.
        clearLog();
        ownAddr = 7'h00;
        busStart();
        writeByte({7'h00, RW_WRITE}, ack);
        checkOutput("t7_zero_nack", ack, NACK);
        busStop();

        // Randomised frames against the transaction-level model.
        for (int t = 0; t < 8; t++) begin
            clearLog();
            bytesQ.delete();
            ownAddr = 7'($urandom_range(1, 127));
            enable = ($urandom_range(0, 3) != 0);
            rAddr = ($urandom_range(0, 1) == 1) ? ownAddr : 7'($urandom_range(0, 127));
            rRw = 1'($urandom_range(0, 1));
            rLen = $urandom_range(1, 3);
            for (int i = 0; i < rLen; i++) bytesQ.push_back(8'($urandom_range(0, 255)));
            expAck = enable && (rAddr == ownAddr) && (ownAddr != 7'h00);
            if (expAck && rRw == RW_READ) foreach (bytesQ[i]) txQueue.push_back(bytesQ[i]);
            busStart();
            writeByte({rAddr, rRw}, ack);
            checkOutput($sformatf("r%0d_addr_ack", t), ack, expAck ? ACK : NACK);
            if (expAck && rRw == RW_WRITE) begin
                for (int i = 0; i < rLen; i++) begin
                    writeByte(bytesQ[i], ack);
                    checkOutput($sformatf("r%0d_wack%0d", t, i), ack, ACK);
                end
            end else if (expAck) begin
                for (int i = 0; i < rLen; i++) begin
                    readByte((i == rLen - 1) ? NACK : ACK, got);
                    checkOutput($sformatf("r%0d_rd%0d", t, i), got, bytesQ[i]);
                end
            end
            busStop();
            checkOutput($sformatf("r%0d_rxcount", t), rxCount,
                        (expAck && rRw == RW_WRITE) ? rLen : 0);
            checkOutput($sformatf("r%0d_txcount", t), txReqCount,
                        (expAck && rRw == RW_READ) ? rLen : 0);
            if (expAck && rRw == RW_WRITE)
                for (int i = 0; i < rLen; i++)
                    checkOutput($sformatf("r%0d_rx%0d", t, i), logAt(i), bytesQ[i]);
            checkOutput($sformatf("r%0d_stop", t), stopCount, 1);
        end

        checkOutput("int_consistent", intErr, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
